// File: rtl/onewire_defs.sv
// Shared 1-wire definitions: FSM state encodings, default timing constants
// in microseconds, and small helpers used by both the slave and the master.
package onewire_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOW       = 3'd1,
        ST_PRES_WAIT = 3'd2,
        ST_PRES_DRV  = 3'd3,
        ST_HOLD      = 3'd4
    } ow_state_t;

    localparam int OW_CDR   = 24;
    localparam int OW_T_RST = 400;
    localparam int OW_T_SMP = 30;
    localparam int OW_T_PDH = 30;
    localparam int OW_T_PDL = 120;
    localparam int OW_T_RD  = 30;

    function automatic logic [2:0] bit_cnt_next(input logic [2:0] cnt);
        return cnt + 3'd1;
    endfunction

endpackage

// File: rtl/onewire_slave.sv
// 1-wire bus slave: reset/presence handling, byte receive with LSB-first
// bit slots, and byte transmit by pulling the bus low for 0 bits.
module onewire_slave
    import onewire_defs::*;
#(
    parameter int CDR   = OW_CDR,
    parameter int T_RST = OW_T_RST,
    parameter int T_SMP = OW_T_SMP,
    parameter int T_PDH = OW_T_PDH,
    parameter int T_PDL = OW_T_PDL,
    parameter int T_RD  = OW_T_RD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       owr_i,
    output logic       owr_oe,
    output logic       bus_rst,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    input  logic [7:0] tx_dat,
    input  logic       tx_ld,
    output logic       tx_busy
);

    localparam int PW = (CDR > 1) ? $clog2(CDR) : 1;
    localparam int UW = $clog2(T_RST + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(CDR - 1);
    localparam logic [UW-1:0] US_SAT  = UW'(T_RST);
    localparam logic [UW-1:0] US_SMP  = UW'(T_SMP - 1);
    localparam logic [UW-1:0] US_RD   = UW'(T_RD - 1);
    localparam logic [UW-1:0] US_PDH  = UW'(T_PDH - 1);
    localparam logic [UW-1:0] US_PDL  = UW'(T_PDL - 1);

    logic          sync1_r, sync2_r, bus_d_r;
    logic          fall_s, rise_s, owr_s;
    logic [PW-1:0] pre_cnt_r;
    logic          tick_s;
    logic [UW-1:0] us_cnt_r;

    ow_state_t     state_r, state_nxt_s;
    logic          us_clr_s, slot_start_s, rel_short_s, rst_det_s;

    logic          slot_act_r, pend_r, tx_slot_r, drv_r, drv_nxt_s;
    logic          sample_s, commit_s, commit_bit_s;
    logic [2:0]    bit_cnt_r, tx_cnt_r;
    logic [7:0]    rx_sh_r, tx_sh_r;
    logic          rx_done_r, tx_busy_r;
    logic          oe_r, bus_rst_r, rx_stb_r;
    logic [7:0]    rx_dat_r;

    assign owr_s  = sync2_r;
    assign fall_s = bus_d_r & ~sync2_r;
    assign rise_s = ~bus_d_r & sync2_r;
    assign tick_s = (pre_cnt_r == PRE_MAX);

    // Bus synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            bus_d_r <= 1'b1;
        end else begin
            sync1_r <= owr_i;
            sync2_r <= sync1_r;
            bus_d_r <= sync2_r;
        end
    end

    // Microsecond prescaler and saturating microsecond counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= '0;
            us_cnt_r  <= '0;
        end else begin
            if (fall_s || us_clr_s || tick_s) begin
                pre_cnt_r <= '0;
            end else begin
                pre_cnt_r <= pre_cnt_r + PW'(1);
            end
            if (us_clr_s) begin
                us_cnt_r <= '0;
            end else if (tick_s && (us_cnt_r != US_SAT)) begin
                us_cnt_r <= us_cnt_r + UW'(1);
            end else begin
                us_cnt_r <= us_cnt_r;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; falling edges outside IDLE are ignored.
    always_comb begin
        state_nxt_s  = state_r;
        us_clr_s     = 1'b0;
        slot_start_s = 1'b0;
        rel_short_s  = 1'b0;
        rst_det_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s  = ST_LOW;
                    us_clr_s     = 1'b1;
                    slot_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    if (us_cnt_r == US_SAT) begin
                        state_nxt_s = ST_PRES_WAIT;
                        us_clr_s    = 1'b1;
                        rst_det_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        rel_short_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            ST_PRES_WAIT: begin
                if (tick_s && (us_cnt_r == US_PDH)) begin
                    state_nxt_s = ST_PRES_DRV;
                    us_clr_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_PRES_WAIT;
                end
            end
            ST_PRES_DRV: begin
                if (tick_s && (us_cnt_r == US_PDL)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_PRES_DRV;
                end
            end
            ST_HOLD: begin
                if (owr_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A low sample is only committed once the slot ends short, so an
    // over-long low that turns into a bus reset never counts as a bit.
    assign sample_s     = slot_act_r && tick_s && (us_cnt_r == US_SMP) &&
                          ((state_r == ST_LOW) || (state_r == ST_IDLE));
    assign commit_s     = (sample_s && owr_s) || (rel_short_s && pend_r);
    assign commit_bit_s = sample_s & owr_s;

    // Data-slot drive decision: 0 bits hold the bus low until T_RD.
    always_comb begin
        drv_nxt_s = drv_r;
        if (rst_det_s) begin
            drv_nxt_s = 1'b0;
        end else if (slot_start_s) begin
            drv_nxt_s = tx_busy_r & ~tx_sh_r[0];
        end else if (drv_r && tick_s && (us_cnt_r == US_RD)) begin
            drv_nxt_s = 1'b0;
        end else begin
            drv_nxt_s = drv_r;
        end
    end

    // Slot tracking, receive shifter and transmit shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_act_r <= 1'b0;
            pend_r     <= 1'b0;
            tx_slot_r  <= 1'b0;
            drv_r      <= 1'b0;
            bit_cnt_r  <= 3'd0;
            rx_sh_r    <= 8'h00;
            rx_done_r  <= 1'b0;
            tx_sh_r    <= 8'h00;
            tx_cnt_r   <= 3'd0;
            tx_busy_r  <= 1'b0;
        end else if (rst_det_s) begin
            slot_act_r <= 1'b0;
            pend_r     <= 1'b0;
            tx_slot_r  <= 1'b0;
            drv_r      <= 1'b0;
            bit_cnt_r  <= 3'd0;
            rx_sh_r    <= 8'h00;
            rx_done_r  <= 1'b0;
            tx_cnt_r   <= 3'd0;
            tx_busy_r  <= 1'b0;
        end else begin
            drv_r <= drv_nxt_s;
            if (slot_start_s) begin
                slot_act_r <= 1'b1;
            end else if (sample_s) begin
                slot_act_r <= 1'b0;
            end else begin
                slot_act_r <= slot_act_r;
            end
            if (sample_s && !owr_s) begin
                pend_r <= 1'b1;
            end else if (rel_short_s) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
            if (slot_start_s) begin
                tx_slot_r <= tx_busy_r;
            end else if (commit_s) begin
                tx_slot_r <= 1'b0;
            end else begin
                tx_slot_r <= tx_slot_r;
            end
            if (commit_s) begin
                rx_sh_r   <= {commit_bit_s, rx_sh_r[7:1]};
                bit_cnt_r <= bit_cnt_next(bit_cnt_r);
                rx_done_r <= (bit_cnt_r == 3'd7);
            end else begin
                rx_done_r <= 1'b0;
            end
            if (commit_s && tx_slot_r) begin
                tx_sh_r  <= {1'b0, tx_sh_r[7:1]};
                tx_cnt_r <= bit_cnt_next(tx_cnt_r);
                if (tx_cnt_r == 3'd7) begin
                    tx_busy_r <= 1'b0;
                end else begin
                    tx_busy_r <= tx_busy_r;
                end
            end else if (tx_ld && !tx_busy_r) begin
                tx_sh_r   <= tx_dat;
                tx_cnt_r  <= 3'd0;
                tx_busy_r <= 1'b1;
            end else begin
                tx_busy_r <= tx_busy_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe_r      <= 1'b0;
            bus_rst_r <= 1'b0;
            rx_stb_r  <= 1'b0;
            rx_dat_r  <= 8'h00;
        end else begin
            oe_r      <= drv_nxt_s | (state_nxt_s == ST_PRES_DRV);
            bus_rst_r <= rst_det_s;
            rx_stb_r  <= rx_done_r;
            if (rx_done_r) begin
                rx_dat_r <= rx_sh_r;
            end else begin
                rx_dat_r <= rx_dat_r;
            end
        end
    end

    assign owr_oe  = oe_r;
    assign bus_rst = bus_rst_r;
    assign rx_stb  = rx_stb_r;
    assign rx_dat  = rx_dat_r;
    assign tx_busy = tx_busy_r;

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: a bus master model drives slots on a
// wired-AND bus (CDR reduced to 4 so 1 us = 4 clocks = 40 time units).
module tb_onewire_slave;

    localparam int US = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_drv = 1'b1;
    logic       owr_i;
    logic       owr_oe, bus_rst, rx_stb, tx_busy;
    logic [7:0] rx_dat;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_ld = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int rst_pulses = 0;
    int stb_pulses = 0;

    assign owr_i = m_drv & ~owr_oe;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_rst) rst_pulses <= rst_pulses + 1;
        if (rx_stb) stb_pulses <= stb_pulses + 1;
    end

    onewire_slave #(.CDR(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .owr_i   (owr_i),
        .owr_oe  (owr_oe),
        .bus_rst (bus_rst),
        .rx_dat  (rx_dat),
        .rx_stb  (rx_stb),
        .tx_dat  (tx_dat),
        .tx_ld   (tx_ld),
        .tx_busy (tx_busy)
    );

    task automatic write_slot(input logic b);
        m_drv = 1'b0;
        #((b ? 6 : 60) * US);
        m_drv = 1'b1;
        #((b ? 64 : 10) * US);
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) write_slot(d[i]);
    endtask

    task automatic read_slot(output logic lvl);
        m_drv = 1'b0;
        #(6 * US);
        m_drv = 1'b1;
        #(14 * US);
        lvl = owr_i;
        #(50 * US);
    endtask

    task automatic bus_reset_pulse();
        m_drv = 1'b0;
        #(480 * US);
        m_drv = 1'b1;
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_dat = d;
        tx_ld = 1'b1;
        #10;
        tx_ld = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #20;
        n_tests++; if (owr_oe !== 1'b0) begin n_fail++; $display("FAIL reset_owr_oe: got %b want 0", owr_oe); end
        n_tests++; if (bus_rst !== 1'b0) begin n_fail++; $display("FAIL reset_bus_rst: got %b want 0", bus_rst); end
        n_tests++; if (rx_stb !== 1'b0) begin n_fail++; $display("FAIL reset_rx_stb: got %b want 0", rx_stb); end
        n_tests++; if (rx_dat !== 8'h00) begin n_fail++; $display("FAIL reset_rx_dat: got %h want 00", rx_dat); end
        n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        reset_n = 1'b1;
        #(10 * US);
    endtask

    task automatic test_bus_reset();
        int r0;
        r0 = rst_pulses;
        bus_reset_pulse();
        #(28 * US);
        n_tests++; if (owr_oe !== 1'b0) begin n_fail++; $display("FAIL pres_before: got %b want 0", owr_oe); end
        #(4 * US);
        n_tests++; if (owr_oe !== 1'b1) begin n_fail++; $display("FAIL pres_start: got %b want 1", owr_oe); end
        n_tests++; if (owr_i !== 1'b0) begin n_fail++; $display("FAIL pres_bus_low: got %b want 0", owr_i); end
        #(116 * US);
        n_tests++; if (owr_oe !== 1'b1) begin n_fail++; $display("FAIL pres_end_hold: got %b want 1", owr_oe); end
        #(4 * US);
        n_tests++; if (owr_oe !== 1'b0) begin n_fail++; $display("FAIL pres_released: got %b want 0", owr_oe); end
        n_tests++; if (rst_pulses - r0 !== 1) begin n_fail++; $display("FAIL bus_rst_count: got %0d want 1", rst_pulses - r0); end
        #(20 * US);
    endtask

    task automatic test_write_a5();
        int s0;
        s0 = stb_pulses;
        write_byte(8'hA5);
        n_tests++; if (stb_pulses - s0 !== 1) begin n_fail++; $display("FAIL a5_stb_count: got %0d want 1", stb_pulses - s0); end
        n_tests++; if (rx_dat !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_dat: got %h want a5", rx_dat); end
    endtask

    task automatic test_tx_3c();
        int s0;
        logic lvl;
        logic [7:0] exp_bits;
        exp_bits = 8'h3C;
        s0 = stb_pulses;
        load_tx(8'h3C);
        n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_set: got %b want 1", tx_busy); end
        for (int i = 0; i < 8; i++) begin
            read_slot(lvl);
            n_tests++;
            if (lvl !== exp_bits[i]) begin n_fail++; $display("FAIL tx_slot%0d_level: got %b want %b", i, lvl, exp_bits[i]); end
            if (i == 6) begin
                n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_busy_slot6: got %b want 1", tx_busy); end
            end
        end
        n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_busy_done: got %b want 0", tx_busy); end
        n_tests++; if (rx_dat !== 8'h3C) begin n_fail++; $display("FAIL tx_echo_rx_dat: got %h want 3c", rx_dat); end
        n_tests++; if (stb_pulses - s0 !== 1) begin n_fail++; $display("FAIL tx_stb_count: got %0d want 1", stb_pulses - s0); end
    endtask

    task automatic test_reset_mid_byte();
        int r0, s0;
        load_tx(8'hFF);
        write_slot(1'b0);
        write_slot(1'b1);
        write_slot(1'b0);
        n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", tx_busy); end
        r0 = rst_pulses;
        s0 = stb_pulses;
        bus_reset_pulse();
        #(200 * US);
        n_tests++; if (rst_pulses - r0 !== 1) begin n_fail++; $display("FAIL mid_bus_rst: got %0d want 1", rst_pulses - r0); end
        n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_cleared: got %b want 0", tx_busy); end
        write_byte(8'hFF);
        n_tests++; if (rx_dat !== 8'hFF) begin n_fail++; $display("FAIL mid_rx_dat: got %h want ff", rx_dat); end
        n_tests++; if (stb_pulses - s0 !== 1) begin n_fail++; $display("FAIL mid_stb_count: got %0d want 1", stb_pulses - s0); end
    endtask

    task automatic test_back_to_back_ld();
        logic lvl;
        load_tx(8'h00);
        read_slot(lvl);
        n_tests++; if (lvl !== 1'b0) begin n_fail++; $display("FAIL b2b_slot0: got %b want 0", lvl); end
        load_tx(8'hFF);
        for (int i = 1; i < 8; i++) begin
            read_slot(lvl);
            n_tests++;
            if (lvl !== 1'b0) begin n_fail++; $display("FAIL b2b_slot%0d: got %b want 0", i, lvl); end
        end
        n_tests++; if (rx_dat !== 8'h00) begin n_fail++; $display("FAIL b2b_rx_dat: got %h want 00", rx_dat); end
        n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_reset_in_presence();
        int s0;
        bus_reset_pulse();
        #(60 * US);
        n_tests++; if (owr_oe !== 1'b1) begin n_fail++; $display("FAIL rip_in_pres: got %b want 1", owr_oe); end
        reset_n = 1'b0;
        #2;
        n_tests++; if (owr_oe !== 1'b0) begin n_fail++; $display("FAIL rip_oe_async: got %b want 0", owr_oe); end
        #8;
        reset_n = 1'b1;
        #(40 * US);
        n_tests++; if (owr_oe !== 1'b0) begin n_fail++; $display("FAIL rip_idle_oe: got %b want 0", owr_oe); end
        n_tests++; if (owr_i !== 1'b1) begin n_fail++; $display("FAIL rip_idle_bus: got %b want 1", owr_i); end
        s0 = stb_pulses;
        write_byte(8'h96);
        n_tests++; if (rx_dat !== 8'h96) begin n_fail++; $display("FAIL rip_rx_dat: got %h want 96", rx_dat); end
        n_tests++; if (stb_pulses - s0 !== 1) begin n_fail++; $display("FAIL rip_stb_count: got %0d want 1", stb_pulses - s0); end
    endtask

    initial begin
        test_reset();
        test_bus_reset();
        test_write_a5();
        test_tx_3c();
        test_reset_mid_byte();
        test_back_to_back_ld();
        test_reset_in_presence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onewire_slave.md
ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 Parameter CDR, default 24, SHALL set system clocks per 1 us timing tick (24 MHz clk).
REQ-002 Parameter T_RST, default 400, SHALL set the minimum bus-low time in us recognised as a reset pulse.
REQ-003 Parameter T_SMP, default 30, SHALL set the us from the falling edge to the data sample point.
REQ-004 Parameter T_PDH, default 30, SHALL set the us from reset-pulse release to the start of the presence pulse.
REQ-005 Parameter T_PDL, default 120, SHALL set the presence pulse length in us.
REQ-006 Parameter T_RD, default 30, SHALL set the us the bus is held low for a transmitted 0.
REQ-007 Port clk, input, 1: system clock; the block SHALL use this single clock, rising edge.
REQ-008 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-009 Port owr_i, input, 1: 1-wire bus level, asynchronous.
REQ-010 Port owr_oe, output, 1: 1 pulls the bus low; 0 releases it.
REQ-011 Port bus_rst, output, 1: one-cycle pulse on reset-pulse detection.
REQ-012 Port rx_dat, output, 8: last received byte, LSB first on the wire.
REQ-013 Port rx_stb, output, 1: one-cycle pulse when rx_dat updates.
REQ-014 Port tx_dat, input, 8: byte to transmit in the next 8 slots.
REQ-015 Port tx_ld, input, 1: one-cycle load strobe for tx_dat.
REQ-016 Port tx_busy, output, 1: high while a loaded byte has untransmitted bits.

Function
REQ-017 owr_i SHALL pass through a 2-flop synchronizer; all timing SHALL use the synchronized level, and a falling edge SHALL be a 1-to-0 transition of it.
REQ-018 A prescaler SHALL produce a tick every CDR clocks and restart at 0 on each synchronized falling edge; the us counter SHALL increment on each tick and saturate at T_RST.
REQ-019 States SHALL be IDLE, LOW, PRES_WAIT, PRES_DRV, and HOLD.
REQ-020 IDLE: on a falling edge -> LOW, clearing the us counter.
REQ-021 LOW: at us count T_SMP with the bus low, the bit SHALL be sampled; if tx_busy and the current tx bit is 0, owr_oe SHALL assert from the falling edge until count T_RD.
REQ-022 LOW: on bus release with count < T_RST -> IDLE; on release with count >= T_RST -> PRES_WAIT, pulse bus_rst, clear the bit counter, rx shift register, and tx_busy.
REQ-023 PRES_WAIT: after T_PDH us -> PRES_DRV, asserting owr_oe; PRES_DRV: after T_PDL us release owr_oe -> HOLD.
REQ-024 HOLD: wait for the bus to be high, then -> IDLE; falling edges during PRES_WAIT/PRES_DRV SHALL be ignored.
REQ-025 The sampled bit SHALL shift into rx bit 7 (right shift); after the 8th sample, rx_dat SHALL update and rx_stb SHALL pulse on the following clock; the bit counter SHALL wrap 7 -> 0.
REQ-026 The sampled bit is the wired-AND bus value, so echoed transmitted bits SHALL also appear in rx_dat.
REQ-027 tx_ld with tx_busy low SHALL latch tx_dat and set tx_busy; tx_ld while tx_busy is high SHALL be ignored.
REQ-028 tx_busy SHALL clear after the 8th transmitted slot's sample.
REQ-029 A tx_ld arriving during LOW SHALL take effect from the next slot.
REQ-030 A low period exceeding T_RST that started as a data slot SHALL be treated as a reset (REQ-022) and SHALL NOT count as a bit.

Reset
REQ-031 On reset_n low: state IDLE, owr_oe 0, bus_rst 0, rx_stb 0, rx_dat 8'h00, tx_busy 0, all counters 0, synchronizer flops 1.

Structure
REQ-032 State encodings and default timing constants SHALL live in a shared include file onewire_defs, also used by the master.
REQ-033 The design SHALL be a single module with no sub-modules.

Verification
REQ-034 Bus low 480 us, then released -> bus_rst pulse; owr_oe high from 30 to 150 us after release.
REQ-035 After reset, master write slots for 0xA5 (1: 6 us low, 0: 60 us low) -> one rx_stb with rx_dat 8'hA5.
REQ-036 tx_ld with 8'h3C, then 8 read slots (6 us low) -> bus low about 30 us in slots 0,1,6,7; tx_busy falls after slot 7; rx_dat 8'h3C.
REQ-037 Reset pulse after 3 bits of a byte, then 8 slots of 0xFF -> rx_dat 8'hFF with no stale bits; tx_busy cleared by the reset.
REQ-038 Second tx_ld during transmission of 8'h00 -> ignored; 8 slots read 0x00.
REQ-039 reset_n asserted during PRES_DRV -> owr_oe 0 immediately; the block idles until the next falling edge.
